// File: rtl/pkt_frame_pkg.sv
// Shared definitions for the packet framing controller.
//
// Contents:
//   state_t / GAP..DRAIN            framing FSM state encodings
//   ERR_NONE..ERR_LEN               frame_error reason codes (err_code)
//   DEF_HDR_BEATS / DEF_MIN_PAYLOAD / DEF_MAX_PAYLOAD
//                                   default framing geometry in beats
//   len_in_range()                  declared-length window check
package pkt_frame_pkg;

    typedef logic [2:0] state_t;

    localparam state_t GAP     = 3'd0;
    localparam state_t IDLE    = 3'd1;
    localparam state_t HEADER  = 3'd2;
    localparam state_t PAYLOAD = 3'd3;
    localparam state_t TAIL    = 3'd4;
    localparam state_t DRAIN   = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_HDR  = 2'd1;
    localparam logic [1:0] ERR_RUNT = 2'd2;
    localparam logic [1:0] ERR_LEN  = 2'd3;

    localparam int DEF_HDR_BEATS   = 14;
    localparam int DEF_MIN_PAYLOAD = 46;
    localparam int DEF_MAX_PAYLOAD = 1500;

    // Unsigned window test; the length is zero-extended to 32 bits by the caller.
    function automatic logic len_in_range(input logic [31:0] len,
                                          input int          min_len,
                                          input int          max_len);
        return (len >= 32'(min_len)) && (len <= 32'(max_len));
    endfunction

endpackage

// File: rtl/pkt_frame_fsm_beat_counter.sv
// pkt_beat_counter: beat counter used for the header and payload counts.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   clear          restart the count; with enable the current beat counts as 1
//   enable         count one beat (held once the count reaches SAT)
//   cmp_val        compare value
//   count          current count
//   at_sat         count == SAT
//   eq             count == cmp_val
//   next_eq        count + 1 == cmp_val (the beat being counted completes the run)
module pkt_beat_counter
    import pkt_frame_pkg::*;
#(
    parameter int           W   = 8,
    parameter logic [W-1:0] SAT = '1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] cmp_val,
    output logic [W-1:0] count,
    output logic         at_sat,
    output logic         eq,
    output logic         next_eq
);

    assign at_sat  = (count == SAT);
    assign eq      = (count == cmp_val);
    assign next_eq = ((count + W'(1)) == cmp_val);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            // A clearing beat that is also a counted beat starts the run at 1.
            count <= enable ? W'(1) : '0;
        end else if (enable && !at_sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pkt_frame_fsm.sv
// pkt_frame_fsm: frame tracker between the line-side beat stream and the
// header/payload extractors. Follows each frame through header, payload and
// tail, steers the extractor enables and validates the declared length.
//
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   in_valid                   beat qualifier
//   in_ctrl                    1 = frame beat, 0 = inter-frame gap beat
//   in_data                    stream data (pass-through, not inspected)
//   type_length_valid          header decoder: type/length field good
//   packet_size_valid          header decoder: payload_len valid
//   payload_len                declared payload length in beats
//   enable_header              current beat is a header beat (combinational)
//   enable_payload             current beat is a payload beat (combinational)
//   frame_done                 1-cycle pulse, good frame ended
//   frame_error                1-cycle pulse, frame rejected
//   err_code                   reason for the last frame_error (held)
//   hdr_cnt                    header beats accepted in current frame
//   pay_cnt                    payload beats accepted in current frame
//   good_frames, bad_frames    saturating frame totals, only present when
//                              PKT_FRAME_FSM_STATS_EN is defined
//
// State table:
//   GAP     | after reset; wait for a gap beat so a truncated frame is skipped
//   IDLE    | between frames; first frame beat is header beat 1
//   HEADER  | counting header beats; length checked on the last one
//   PAYLOAD | counting payload beats up to the latched length
//   TAIL    | padding/FCS beats; gap beat ends a good frame
//   DRAIN   | discarding the rest of a rejected frame
module pkt_frame_fsm
    import pkt_frame_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int HDR_BEATS   = DEF_HDR_BEATS,
    parameter int LEN_W       = 16,
    parameter int MIN_PAYLOAD = DEF_MIN_PAYLOAD,
    parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD,
    localparam int HC_W       = $clog2(HDR_BEATS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              type_length_valid,
    input  logic              packet_size_valid,
    input  logic [LEN_W-1:0]  payload_len,
    output logic              enable_header,
    output logic              enable_payload,
    output logic              frame_done,
    output logic              frame_error,
    output logic [1:0]        err_code,
    output logic [HC_W-1:0]   hdr_cnt,
    output logic [LEN_W-1:0]  pay_cnt
`ifdef PKT_FRAME_FSM_STATS_EN
    ,
    output logic [31:0]       good_frames,
    output logic [31:0]       bad_frames
`endif
);

    state_t            state;
    logic [LEN_W-1:0]  len_reg;

    logic              frame_beat;
    logic              gap_beat;
    logic              hdr_last;
    logic              hdr_good;
    logic              len_ok;
    logic              pay_next_eq;

    logic              hdr_clear;
    logic              hdr_en;
    logic              pay_clear;
    logic              pay_en;

    logic              unused_hdr_sat;
    logic              unused_hdr_next_eq;
    logic              unused_pay_sat;
    logic              unused_pay_eq;
    logic              unused_data;

    assign unused_data = ^in_data;

    assign frame_beat = in_valid &  in_ctrl;
    assign gap_beat   = in_valid & ~in_ctrl;

    assign hdr_good = type_length_valid & packet_size_valid;
    assign len_ok   = len_in_range(32'(payload_len), MIN_PAYLOAD, MAX_PAYLOAD);

    assign enable_header  = frame_beat & ((state == IDLE) | (state == HEADER));
    assign enable_payload = frame_beat & (state == PAYLOAD);

    // Header count restarts at 1 on the first frame beat seen in IDLE.
    assign hdr_clear = frame_beat & (state == IDLE);
    assign hdr_en    = enable_header;

    assign pay_clear = frame_beat & (state == HEADER) & hdr_last & hdr_good & len_ok;
    assign pay_en    = enable_payload;

    pkt_beat_counter #(
        .W   (HC_W),
        .SAT (HC_W'(HDR_BEATS))
    ) u_hdr_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (hdr_clear),
        .enable  (hdr_en),
        .cmp_val (HC_W'(HDR_BEATS - 1)),
        .count   (hdr_cnt),
        .at_sat  (unused_hdr_sat),
        .eq      (hdr_last),
        .next_eq (unused_hdr_next_eq)
    );

    pkt_beat_counter #(
        .W (LEN_W)
    ) u_pay_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (pay_clear),
        .enable  (pay_en),
        .cmp_val (len_reg),
        .count   (pay_cnt),
        .at_sat  (unused_pay_sat),
        .eq      (unused_pay_eq),
        .next_eq (pay_next_eq)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= GAP;
            len_reg     <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (in_valid) begin
                case (state)
                    GAP: begin
                        if (!in_ctrl) state <= IDLE;
                    end
                    IDLE: begin
                        if (in_ctrl) state <= HEADER;
                    end
                    HEADER: begin
                        if (!in_ctrl) begin
                            state       <= IDLE;
                            frame_error <= 1'b1;
                            err_code    <= ERR_HDR;
                        end else if (hdr_last) begin
                            if (!hdr_good) begin
                                state       <= DRAIN;
                                frame_error <= 1'b1;
                                err_code    <= ERR_HDR;
                            end else if (!len_ok) begin
                                state       <= DRAIN;
                                frame_error <= 1'b1;
                                err_code    <= ERR_LEN;
                            end else begin
                                len_reg <= payload_len;
                                // Only reachable with MIN_PAYLOAD of 0.
                                state   <= (payload_len == '0) ? TAIL : PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (!in_ctrl) begin
                            state       <= IDLE;
                            frame_error <= 1'b1;
                            err_code    <= ERR_RUNT;
                        end else if (pay_next_eq) begin
                            state <= TAIL;
                        end
                    end
                    TAIL: begin
                        if (!in_ctrl) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (!in_ctrl) state <= IDLE;
                    end
                    default: begin
                        state <= GAP;
                    end
                endcase
            end
        end
    end

`ifdef PKT_FRAME_FSM_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            good_frames <= '0;
            bad_frames  <= '0;
        end else begin
            if (frame_done && (good_frames != '1)) good_frames <= good_frames + 32'd1;
            if (frame_error && (bad_frames != '1)) bad_frames <= bad_frames + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_frame_fsm.sv
// Self-checking bench for pkt_frame_fsm (default geometry 14 / 46 / 1500).
// Frame-level vectors come from a table; pulse expectations are queued when
// the triggering beat is driven and matched by a monitor on the falling edge.
module tb_pkt_frame_fsm;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ctrl;
    logic [7:0]  in_data;
    logic        type_length_valid;
    logic        packet_size_valid;
    logic [15:0] payload_len;
    logic        enable_header;
    logic        enable_payload;
    logic        frame_done;
    logic        frame_error;
    logic [1:0]  err_code;
    logic [3:0]  hdr_cnt;
    logic [15:0] pay_cnt;
`ifdef PKT_FRAME_FSM_STATS_EN
    logic [31:0] good_frames;
    logic [31:0] bad_frames;
`endif

    pkt_frame_fsm dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ctrl           (in_ctrl),
        .in_data           (in_data),
        .type_length_valid (type_length_valid),
        .packet_size_valid (packet_size_valid),
        .payload_len       (payload_len),
        .enable_header     (enable_header),
        .enable_payload    (enable_payload),
        .frame_done        (frame_done),
        .frame_error       (frame_error),
        .err_code          (err_code),
        .hdr_cnt           (hdr_cnt),
        .pay_cnt           (pay_cnt)
`ifdef PKT_FRAME_FSM_STATS_EN
        ,
        .good_frames       (good_frames),
        .bad_frames        (bad_frames)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        bit tlv;
        bit psv;
        int len;
        int n_pay;
        int n_tail;
        bit trig_hdr;     // pulse triggered by the last header beat, else by the closing gap beat
        bit exp_done;
        int exp_code;
        int exp_hdr_en;
        int exp_pay_en;
        int exp_pay_cnt;
    } frame_vec_t;

    typedef struct {
        bit done;
        int code;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    frame_vec_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hdr_en_cnt = 0;
    int pay_en_cnt = 0;
    int exp_good = 0;
    int exp_bad  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit done, input int code);
        exp_t e;
        e.done = done;
        e.code = code;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        if (done) exp_good++;
        else      exp_bad++;
    endtask

    // Monitor: enables counted and pulses matched against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (enable_header)  hdr_en_cnt++;
            if (enable_payload) pay_en_cnt++;
            if (frame_done && frame_error) check("done_and_error", 1, 0);
            if (frame_done || frame_error) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got done=%0d error=%0d code=%0d, expected none (cycle %0d)",
                             frame_done, frame_error, err_code, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_is_done", int'(frame_done), int'(e.done));
                    if (!e.done) check("err_code", int'(err_code), e.code);
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic beat(input bit v, input bit c);
        @(posedge clock);
        #1;
        in_valid = v;
        in_ctrl  = c;
        in_data  = 8'($urandom);
    endtask

    task automatic settle();
        beat(0, 0);
        @(negedge clock);
        #1;
    endtask

    task automatic send_frame(input frame_vec_t f, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        hdr_en_cnt = 0;
        pay_en_cnt = 0;
        type_length_valid = f.tlv;
        packet_size_valid = f.psv;
        payload_len       = 16'(f.len);
        beat(1, 0);
        for (int i = 0; i < 14; i++) begin
            beat(1, 1);
            if (i == 13 && f.trig_hdr) push_exp(f.exp_done, f.exp_code);
        end
        for (int i = 0; i < f.n_pay + f.n_tail; i++) beat(1, 1);
        beat(1, 0);
        if (!f.trig_hdr) push_exp(f.exp_done, f.exp_code);
        settle();
        check({tag, "_hdr_en"}, hdr_en_cnt, f.exp_hdr_en);
        check({tag, "_pay_en"}, pay_en_cnt, f.exp_pay_en);
        check({tag, "_pay_cnt"}, int'(pay_cnt), f.exp_pay_cnt);
        check({tag, "_hdr_cnt"}, int'(hdr_cnt), 14);
    endtask

    initial begin
        //          tlv psv len  pay  tail hdr done code hdr_en pay_en pay_cnt
        vecs[0] = '{1, 1, 46,   46,   4,   0,  1,   0,   14,    46,    46};
        vecs[1] = '{0, 1, 46,   46,   4,   1,  0,   1,   14,    0,     46};
        vecs[2] = '{1, 0, 46,   46,   4,   1,  0,   1,   14,    0,     46};
        vecs[3] = '{1, 1, 100,  60,   0,   0,  0,   2,   14,    60,    60};
        vecs[4] = '{1, 1, 1501, 10,   0,   1,  0,   3,   14,    0,     60};
        vecs[5] = '{1, 1, 45,   10,   0,   1,  0,   3,   14,    0,     60};
        vecs[6] = '{1, 1, 1500, 1500, 0,   0,  1,   0,   14,    1500,  1500};
        vecs[7] = '{1, 1, 47,   47,   2,   0,  1,   0,   14,    47,    47};

        reset = 1'b1;
        in_valid = 1'b0;
        in_ctrl = 1'b0;
        in_data = '0;
        type_length_valid = 1'b0;
        packet_size_valid = 1'b0;
        payload_len = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_error", int'(frame_error), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_hdr_cnt", int'(hdr_cnt), 0);
        check("rst_pay_cnt", int'(pay_cnt), 0);
        check("rst_enable_header", int'(enable_header), 0);

        for (int i = 0; i < 8; i++) send_frame(vecs[i], i);

        // Header cut short by a gap beat after 5 beats.
        hdr_en_cnt = 0;
        beat(1, 0);
        for (int i = 0; i < 5; i++) beat(1, 1);
        beat(1, 0);
        push_exp(0, 1);
        settle();
        check("trunc_hdr_cnt", int'(hdr_cnt), 5);
        check("trunc_hdr_en", hdr_en_cnt, 5);
        send_frame(vecs[7], 7);

        // Payload with in_valid stalls; ctrl toggling while invalid must be ignored.
        hdr_en_cnt = 0;
        pay_en_cnt = 0;
        type_length_valid = 1'b1;
        packet_size_valid = 1'b1;
        payload_len = 16'd46;
        beat(1, 0);
        for (int i = 0; i < 14; i++) beat(1, 1);
        for (int i = 0; i < 10; i++) beat(1, 1);
        beat(0, 1);
        #1 check("stall_enable_payload", int'(enable_payload), 0);
        beat(0, 0);
        beat(0, 1);
        beat(0, 0);
        @(negedge clock);
        check("stall_pay_cnt", int'(pay_cnt), 10);
        check("stall_hdr_cnt", int'(hdr_cnt), 14);
        for (int i = 0; i < 36; i++) beat(1, 1);
        beat(1, 0);
        push_exp(1, 0);
        settle();
        check("stall_pay_en", pay_en_cnt, 46);
        check("stall_pay_cnt_end", int'(pay_cnt), 46);

        // Reset in the middle of a payload, with a frame beat presented on the reset cycle.
        payload_len = 16'd100;
        beat(1, 0);
        for (int i = 0; i < 14 + 20; i++) beat(1, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_valid = 1'b1;
        in_ctrl = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_good = 0;
        exp_bad = 0;
        @(negedge clock);
        check("midrst_hdr_cnt", int'(hdr_cnt), 0);
        check("midrst_pay_cnt", int'(pay_cnt), 0);
        check("midrst_err_code", int'(err_code), 0);
        hdr_en_cnt = 0;
        pay_en_cnt = 0;
        for (int i = 0; i < 30; i++) beat(1, 1);
        settle();
        check("midrst_hdr_en", hdr_en_cnt, 0);
        check("midrst_pay_en", pay_en_cnt, 0);
        check("midrst_pay_cnt_after", int'(pay_cnt), 0);
        beat(1, 0);
        send_frame(vecs[0], 0);
        send_frame(vecs[1], 1);

        settle();
`ifdef PKT_FRAME_FSM_STATS_EN
        check("good_frames", int'(good_frames), exp_good);
        check("bad_frames", int'(bad_frames), exp_bad);
`endif
        check("pending_pulses", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
